ltc2324_serial_rx: RTL
======================

LTC2324_SERIAL_RX -- requirements
Module: ltc2324_serial_rx

Interface
REQ-001 SHALL have parameter CNV_HIGH, default 2: CNV high time in adc_clk cycles (legal 1..15).
REQ-002 SHALL have parameter CONV_WAIT, default 45: cycles from CNV fall to first SCK rise (tCONV), legal 1..255.
REQ-003 SHALL have parameter SCK_HALF, default 1: SCK half-period in adc_clk cycles (legal 1..8).
REQ-004 SHALL have parameter USE_SCK_SHIFT_DATA, default 0: 1 = internal test pattern replaces SDO data.
REQ-005 SHALL have port adc_clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port adc_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port sample_en  input  1  level request for continuous conversions.
REQ-008 SHALL have port CNV  output  1  conversion start to ADC, registered.
REQ-009 SHALL have port SCK  output  1  serial clock to ADC, registered.
REQ-010 SHALL have port CLKOUT  input  1  ADC echo clock; unused, kept for pin compatibility.
REQ-011 SHALL have ports SDO1..SDO4  input  1 each  serial data lanes for channels 1..4, MSB first.
REQ-012 SHALL have port valid  output  1  one-cycle pulse: ch1..ch4 updated.
REQ-013 SHALL have ports ch1..ch4  output  16 each  last captured sample per channel, held between pulses.

Function
REQ-014 SHALL implement FSM IDLE -> CNV -> CONV -> SHIFT -> DONE.
REQ-015 IDLE: CNV=0, SCK=0; go to CNV on sample_en=1.
REQ-016 CNV: CNV=1 for exactly CNV_HIGH cycles, then CONV.
REQ-017 CONV: CNV=0, SCK=0 for exactly CONV_WAIT cycles, then SHIFT.
REQ-018 SHIFT: SCK SHALL emit exactly 16 pulses, each SCK_HALF cycles high then SCK_HALF cycles low; then DONE.
REQ-019 Each lane SHALL register its SDO on the adc_clk edge at which SCK is driven 0->1, left-shifting into a 16-bit register (first bit = MSB).
REQ-020 DONE (1 cycle): load ch1..ch4 from the shift registers and assert valid; next state CNV if sample_en=1, else IDLE.
REQ-021 Frame period SHALL be CNV_HIGH + CONV_WAIT + 32*SCK_HALF + 1 cycles (defaults: 80).
REQ-022 sample_en deasserted mid-frame SHALL NOT abort; frame completes with valid, then IDLE.
REQ-023 sample_en is sampled only in IDLE and DONE.
REQ-024 valid SHALL never be asserted in two consecutive cycles.
REQ-025 USE_SCK_SHIFT_DATA=1: identical CNV/SCK timing; SDO ignored; at DONE ch1=frame_cnt, ch2=frame_cnt+1, ch3=~frame_cnt, ch4=16'hA5A5.
REQ-026 frame_cnt: 16-bit, increments after each DONE, wraps 0xFFFF -> 0x0000.
REQ-027 Bit and half-period counters SHALL be sized from parameters with no overflow at legal maxima.

Reset
REQ-028 On adc_rst_n=0, immediately: state=IDLE, CNV=0, SCK=0, valid=0, ch1..ch4=0, shift registers=0, all counters=0, frame_cnt=0.
REQ-029 Reset mid-SHIFT SHALL discard the partial frame; no valid after release.
REQ-030 After release, first CNV rise SHALL occur no earlier than the first clock edge with sample_en=1.

Structure
REQ-031 Package ltc2324_pkg SHALL hold the FSM state enum, data width 16, lane count 4, parameter defaults.
REQ-032 Sub-module ltc2324_lane_shift (one 16-bit shift register plus capture enable) SHALL be instantiated 4 times.

Verification
REQ-033 Defaults, sample_en held 1, SDO model drives 0x1234/0xABCD/0x8000/0x0001 -> valid every 80 cycles, ch1..ch4 match exactly.
REQ-034 Single frame: sample_en pulsed 1 cycle -> one CNV high for 2 cycles, exactly 16 SCK pulses, one valid, then IDLE.
REQ-035 sample_en dropped at SCK pulse 8 -> frame finishes, valid asserted, no further CNV.
REQ-036 adc_rst_n asserted at SCK pulse 5 -> CNV, SCK, valid low same cycle, ch1..ch4=0, no valid until new frame.
REQ-037 SCK_HALF=3, CONV_WAIT=10 -> SCK high 3 / low 3, frame period 2+10+96+1=109 cycles.
REQ-038 USE_SCK_SHIFT_DATA=1, 3 frames -> ch1=0,1,2; ch3=0xFFFF,0xFFFE,0xFFFD; ch4=0xA5A5; frame_cnt wraps after 65536 frames.

Source files
------------

// File: rtl/ltc2324_pkg.sv
// Shared types and constants for the LTC2324 serial receiver.
package ltc2324_pkg;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;

    localparam int CNV_HIGH_DEF   = 2;
    localparam int CONV_WAIT_DEF  = 45;
    localparam int SCK_HALF_DEF   = 1;
    localparam int USE_SCK_SHIFT_DATA_DEF = 0;

    localparam logic [DATA_W-1:0] PATTERN_CH4 = 16'hA5A5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNV   = 3'd1,
        S_CONV  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ltc2324_serial_rx_if.sv
// ADC pins and sample bus of the LTC2324 receiver.
interface ltc2324_serial_rx_if;
    import ltc2324_pkg::*;

    logic              sample_en;
    logic              CNV;
    logic              SCK;
    logic              CLKOUT;
    logic              SDO1;
    logic              SDO2;
    logic              SDO3;
    logic              SDO4;
    logic              valid;
    logic [DATA_W-1:0] ch1;
    logic [DATA_W-1:0] ch2;
    logic [DATA_W-1:0] ch3;
    logic [DATA_W-1:0] ch4;

    // Side that requests samples and models the ADC.
    modport master (
        output sample_en, CLKOUT, SDO1, SDO2, SDO3, SDO4,
        input  CNV, SCK, valid, ch1, ch2, ch3, ch4
    );

    // Receiver side.
    modport slave (
        input  sample_en, CLKOUT, SDO1, SDO2, SDO3, SDO4,
        output CNV, SCK, valid, ch1, ch2, ch3, ch4
    );

endinterface

// File: rtl/ltc2324_lane_shift.sv
// One SDO lane: 16-bit MSB-first shift register, advanced on capture enable.
module ltc2324_lane_shift
    import ltc2324_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cap_en_i,
    input  logic              sdo_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shift_q;

    // Shift the lane bit in at each SCK rising edge; first bit ends up as MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else if (cap_en_i) begin
            shift_q <= {shift_q[DATA_W-2:0], sdo_i};
        end
    end

    assign data_o = shift_q;

endmodule

// File: rtl/ltc2324_serial_rx.sv
// LTC2324 conversion sequencer and 4-lane serial receiver.
// CNV/SCK/valid are registered from the next-state values so they line up
// exactly with the state the FSM is in during each cycle.
module ltc2324_serial_rx
    import ltc2324_pkg::*;
#(
    parameter int CNV_HIGH           = CNV_HIGH_DEF,
    parameter int CONV_WAIT          = CONV_WAIT_DEF,
    parameter int SCK_HALF           = SCK_HALF_DEF,
    parameter int USE_SCK_SHIFT_DATA = USE_SCK_SHIFT_DATA_DEF
)(
    input  logic adc_clk,
    input  logic adc_rst_n,
    ltc2324_serial_rx_if.slave bus
);

    localparam int WAIT_MAX = (CNV_HIGH > CONV_WAIT) ? CNV_HIGH : CONV_WAIT;
    localparam int WCW      = $clog2(WAIT_MAX + 1);
    localparam int HCW      = $clog2(SCK_HALF + 1);
    localparam int BCW      = $clog2(DATA_W);

    state_e            state_q, state_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;     // CNV-high / tCONV cycle counter
    logic [HCW-1:0]    hcnt_q, hcnt_d;     // cycles within one SCK half
    logic              phase_q, phase_d;   // 0 = SCK high half, 1 = low half
    logic [BCW-1:0]    bit_q, bit_d;       // SCK pulse index 0..15

    logic              cnv_q, sck_q, valid_q;
    logic              sck_d;
    logic              cap_en;
    logic [DATA_W-1:0] frame_q;
    logic [DATA_W-1:0] ch_q      [LANES];
    logic [DATA_W-1:0] lane_data [LANES];
    logic [DATA_W-1:0] load_val  [LANES];
    logic [LANES-1:0]  sdo;

    assign sdo = {bus.SDO4, bus.SDO3, bus.SDO2, bus.SDO1};

    // State and counter registers.
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state and counter sequencing for one conversion frame.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.sample_en) begin
                    state_d = S_CNV;
                    wcnt_d  = '0;
                end
            end
            S_CNV: begin
                if (wcnt_q == WCW'(CNV_HIGH - 1)) begin
                    state_d = S_CONV;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_CONV: begin
                if (wcnt_q == WCW'(CONV_WAIT - 1)) begin
                    state_d = S_SHIFT;
                    hcnt_d  = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_SHIFT: begin
                if (hcnt_q == HCW'(SCK_HALF - 1)) begin
                    hcnt_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (bit_q == BCW'(DATA_W - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            bit_d = bit_q + BCW'(1);
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + HCW'(1);
                end
            end
            S_DONE: begin
                state_d = bus.sample_en ? S_CNV : S_IDLE;
                wcnt_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sck_d  = (state_d == S_SHIFT) && !phase_d;
    // SDO is sampled on the same edge that drives SCK low-to-high.
    assign cap_en = sck_d && !sck_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ltc2324_lane_shift u_lane (
            .clk_i    (adc_clk),
            .rst_ni   (adc_rst_n),
            .cap_en_i (cap_en),
            .sdo_i    (sdo[g]),
            .data_o   (lane_data[g])
        );
    end

    // Select captured lane data or the built-in frame-counter test pattern.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            load_val[i] = lane_data[i];
        end
        if (USE_SCK_SHIFT_DATA != 0) begin
            load_val[0] = frame_q;
            load_val[1] = frame_q + DATA_W'(1);
            load_val[2] = ~frame_q;
            load_val[3] = PATTERN_CH4;
        end
    end

    // Registered pin outputs, sample hold registers and frame counter.
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            cnv_q   <= 1'b0;
            sck_q   <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            cnv_q   <= (state_d == S_CNV);
            sck_q   <= sck_d;
            valid_q <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                frame_q <= frame_q + DATA_W'(1);
                for (int i = 0; i < LANES; i++) begin
                    ch_q[i] <= load_val[i];
                end
            end
        end
    end

    assign bus.CNV   = cnv_q;
    assign bus.SCK   = sck_q;
    assign bus.valid = valid_q;
    assign bus.ch1   = ch_q[0];
    assign bus.ch2   = ch_q[1];
    assign bus.ch3   = ch_q[2];
    assign bus.ch4   = ch_q[3];

endmodule
